// File: rtl/modport_array_pkg.sv
// Shared constants and types for the modport_array lane-routing block.
package modport_array_pkg;

    // Default number of lanes, which is also the default counter width.
    localparam int unsigned LANES_DEFAULT = 4;

    // One bit per lane at the default width.
    typedef logic [LANES_DEFAULT-1:0] lane_vec_t;

endpackage : modport_array_pkg

// File: rtl/modport_array_lane_if.sv
// Single-bit lane interface. The producer of a lane binds to the source
// modport and the consumer binds to the sink modport.
interface lane_if;

    logic a;

    modport source (output a);
    modport sink   (input  a);

endinterface : lane_if

// File: rtl/modport_array.sv
// Free-running N-bit counter whose bits are exposed twice: once directly and
// once after a round trip through an array of lane interfaces. A sticky flag
// records any clock edge on which the two copies disagree.
module modport_array
    import modport_array_pkg::*;
#(
    parameter int N = LANES_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    output logic [N-1:0] cnt,
    output logic [N-1:0] direct,
    output logic [N-1:0] routed,
    output logic         mismatch,
    output logic         done
);

    logic [N-1:0] cnt_q;
    logic [N-1:0] cnt_d;
    logic         mismatch_q;
    logic         mismatch_d;

    // Unpacked array of lane interfaces. Lane i carries cnt[i] from its
    // source side to its sink side with no storage in between.
    lane_if lane [N-1:0] ();

    // Lane i's source side is written from the counter bit, and routed[i] is
    // taken from the same lane's sink side.
    for (genvar i = 0; i < N; i++) begin : g_lane
        assign lane[i].a = cnt_q[i];
        assign routed[i] = lane[i].a;
    end

    assign cnt    = cnt_q;
    assign direct = cnt_q;
    assign done   = &cnt_q;

    // Next-state: counter wraps naturally at 2^N; mismatch is sticky.
    always_comb begin
        cnt_d      = cnt_q + N'(1);
        mismatch_d = mismatch_q;
        if (direct != routed) begin
            mismatch_d = 1'b1;
        end
    end

    // State register with synchronous reset, which takes priority over counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            mismatch_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign mismatch = mismatch_q;

endmodule : modport_array

// File: tb/tb_modport_array.sv
// Bench for modport_array at N = 4, 1 and 8, driven by a shared clock and
// reset and checked against an integer counter model for each width.
module tb_modport_array;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [3:0] cnt4, direct4, routed4;
    logic       mismatch4, done4;
    logic [0:0] cnt1, direct1, routed1;
    logic       mismatch1, done1;
    logic [7:0] cnt8, direct8, routed8;
    logic       mismatch8, done8;

    int n_vec = 0;
    int n_err = 0;

    // Reference counters. Each one is the number of edges since reset,
    // taken modulo 2^N.
    int m4 = 0, m1 = 0, m8 = 0;
    int cycle = 0;

    always #5 clk = ~clk;

    modport_array #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .cnt(cnt4), .direct(direct4), .routed(routed4),
        .mismatch(mismatch4), .done(done4)
    );
    modport_array #(.N(1)) dut1 (
        .clk(clk), .rst(rst), .cnt(cnt1), .direct(direct1), .routed(routed1),
        .mismatch(mismatch1), .done(done1)
    );
    modport_array #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .cnt(cnt8), .direct(direct8), .routed(routed8),
        .mismatch(mismatch8), .done(done8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    // Apply one rising edge, advance the models using the reset value that
    // was presented, and then wait for outputs to settle before they are sampled.
    task automatic step();
        @(posedge clk);
        cycle++;
        if (rst) begin
            m4 = 0; m1 = 0; m8 = 0;
        end else begin
            m4 = (m4 + 1) % 16;
            m1 = (m1 + 1) % 2;
            m8 = (m8 + 1) % 256;
        end
        #1;
    endtask

    task automatic check_all();
        chk("cnt4",      32'(cnt4),      32'(m4));
        chk("direct4",   32'(direct4),   32'(m4));
        chk("routed4",   32'(routed4),   32'(m4));
        chk("done4",     32'(done4),     32'(m4 == 15));
        chk("mismatch4", 32'(mismatch4), 32'(0));
        chk("cnt1",      32'(cnt1),      32'(m1));
        chk("direct1",   32'(direct1),   32'(m1));
        chk("routed1",   32'(routed1),   32'(m1));
        chk("done1",     32'(done1),     32'(m1 == 1));
        chk("mismatch1", 32'(mismatch1), 32'(0));
        chk("cnt8",      32'(cnt8),      32'(m8));
        chk("direct8",   32'(direct8),   32'(m8));
        chk("routed8",   32'(routed8),   32'(m8));
        chk("done8",     32'(done8),     32'(m8 == 255));
        chk("mismatch8", 32'(mismatch8), 32'(0));
    endtask

    initial begin
        int last1;
        int last8;
        int guard;

        // Reset is held for two edges.
        rst = 1'b1;
        step();
        step();
        chk("rst_cnt4",    32'(cnt4),      32'h0);
        chk("rst_direct4", 32'(direct4),   32'h0);
        chk("rst_routed4", 32'(routed4),   32'h0);
        chk("rst_mis4",    32'(mismatch4), 32'h0);
        chk("rst_done4",   32'(done4),     32'h0);
        check_all();

        // Release reset and apply 15 edges, which brings the N=4 counter to all ones.
        rst = 1'b0;
        for (int i = 0; i < 15; i++) step();
        chk("top_cnt4",    32'(cnt4),    32'hF);
        chk("top_done4",   32'(done4),   32'h1);
        chk("top_direct4", 32'(direct4), 32'hF);
        chk("top_routed4", 32'(routed4), 32'hF);

        // The next edge wraps the counter.
        step();
        chk("wrap_cnt4",  32'(cnt4),  32'h0);
        chk("wrap_done4", 32'(done4), 32'h0);

        // Three full N=4 periods, with every output checked on each cycle.
        for (int i = 0; i < 48; i++) begin
            step();
            check_all();
        end

        // Assert reset mid-count, on the cycle where cnt4 reads 5.
        guard = 0;
        while (m4 != 5 && guard < 20) begin
            step();
            guard++;
        end
        chk("reach5_cnt4", 32'(cnt4), 32'h5);
        rst = 1'b1;
        step();
        chk("midrst_cnt4", 32'(cnt4), 32'h0);
        rst = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            step();
            chk("resume_cnt4", 32'(cnt4), 32'(i));
            chk("resume_done4", 32'(done4), 32'(i == 15));
        end

        // Run 600 cycles with no reset and measure the spacing between
        // done pulses at N=1 and N=8.
        last1 = -1;
        last8 = -1;
        for (int i = 0; i < 600; i++) begin
            step();
            check_all();
            if (done1) begin
                if (last1 >= 0) chk("period1", 32'(cycle - last1), 32'd2);
                last1 = cycle;
            end
            if (done8) begin
                if (last8 >= 0) chk("period8", 32'(cycle - last8), 32'd256);
                last8 = cycle;
            end
        end
        chk("saw_done8", 32'(last8 >= 0), 32'd1);

        // Random resets: each edge has roughly a 1-in-12 chance of reset.
        for (int i = 0; i < 500; i++) begin
            rst = ($urandom_range(0, 11) == 0);
            step();
            check_all();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_modport_array
